sine_serial_source: RTL

Sample generator feeding the serial-input DAC model in the sine-synthesis chain. On each sample `tick` from the tick counter, it advances a phase accumulator and looks up a quarter-wave sine ROM. It then forms an offset-binary code and shifts it out MSB-first on `SO`/`SI_en`, followed by a one-cycle `soc` start-of-conversion strobe. It runs on the 200 MHz PLL clock alongside the tick counter and the DAC.

---
 rtl/sine_serial_source_if.sv | 24 ++
 rtl/sine_serial_source.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/sine_serial_source_if.sv
// Sample-strobe inputs and serial DAC outputs of the sine sample generator.
// The generator side uses the slave modport.
interface sine_serial_source_if #(
    parameter int PHASE_W = 10
);
    logic               en;
    logic               tick;
    logic [PHASE_W-1:0] step;
    logic               SO;
    logic               SI_en;
    logic               soc;
    logic               busy;
    logic               overrun;

    modport master (
        output en, tick, step,
        input  SO, SI_en, soc, busy, overrun
    );

    modport slave (
        input  en, tick, step,
        output SO, SI_en, soc, busy, overrun
    );
endinterface

// File: rtl/sine_serial_source.sv
// Phase-accumulator sine generator with quarter-wave ROM,
// serialising offset-binary codes MSB-first to a serial DAC.
module sine_serial_source #(
    parameter int DATA_W  = 12,
    parameter int PHASE_W = 10
) (
    input logic                  clk,
    input logic                  rst_n,
    sine_serial_source_if.slave  bus
);
    localparam int IW = PHASE_W - 2;
    localparam int N  = 1 << IW;
    localparam int MW = DATA_W - 1;
    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST = CW'(DATA_W);

    // Quarter-wave table, sampled at bin centres so mirroring is exact.
    function automatic logic [N*MW-1:0] gen_rom();
        logic [N*MW-1:0] r;
        real x, s, t, amp;
        int  v;
        r   = '0;
        amp = real'((1 << MW) - 1);
        for (int i = 0; i < N; i++) begin
            x = 3.14159265358979323846 / 2.0
                * (real'(i) + 0.5) / real'(N);
            s = x;
            t = x;
            for (int k = 1; k < 12; k++) begin
                t = -t * x * x / real'((2 * k) * (2 * k + 1));
                s = s + t;
            end
            v = $rtoi(amp * s + 0.5);
            r[i*MW +: MW] = MW'(v);
        end
        return r;
    endfunction

    localparam logic [N*MW-1:0] QROM = gen_rom();

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, SHIFT, SOC
    } state_t;

    state_t              state, state_d;
    logic [PHASE_W-1:0]  phase, phase_d;
    logic [PHASE_W-1:0]  step_q, step_d;
    logic [1:0]          q_q, q_d;
    logic [MW-1:0]       mag;
    logic [DATA_W-1:0]   sh, sh_d;
    logic [CW-1:0]       cnt, cnt_d;
    logic                so_q, so_d;
    logic                si_en_q, si_en_d;
    logic                soc_q, soc_d;
    logic                busy_q, busy_d;
    logic                ovr_q, ovr_d;
    logic [IW-1:0]       idx;
    logic [DATA_W-1:0]   code;

    assign idx = phase[IW-1:0] ^ {IW{phase[PHASE_W-2]}};

    // Lower half-wave mirrors the upper one about mid-scale.
    assign code = q_q[1] ? {1'b0, ~mag} : {1'b1, mag};

    always_comb begin
        state_d = state;
        phase_d = phase;
        step_d  = step_q;
        q_d     = q_q;
        sh_d    = sh;
        cnt_d   = cnt;
        so_d    = 1'b0;
        si_en_d = 1'b0;
        soc_d   = 1'b0;
        busy_d  = busy_q;
        ovr_d   = bus.tick && (state != IDLE);
        unique case (state)
            IDLE: begin
                if (bus.tick && bus.en) begin
                    state_d = FETCH;
                    step_d  = bus.step;
                    busy_d  = 1'b1;
                end else if (!bus.en) begin
                    phase_d = '0;
                end
            end
            FETCH: begin
                q_d     = phase[PHASE_W-1:PHASE_W-2];
                phase_d = phase + step_q;
                state_d = LOAD;
            end
            LOAD: begin
                so_d    = code[DATA_W-1];
                si_en_d = 1'b1;
                sh_d    = {code[DATA_W-2:0], 1'b0};
                cnt_d   = CW'(1);
                state_d = SHIFT;
            end
            SHIFT: begin
                if (cnt == LAST) begin
                    soc_d   = 1'b1;
                    state_d = SOC;
                end else begin
                    so_d    = sh[DATA_W-1];
                    si_en_d = 1'b1;
                    sh_d    = {sh[DATA_W-2:0], 1'b0};
                    cnt_d   = cnt + CW'(1);
                end
            end
            SOC: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            phase   <= '0;
            step_q  <= '0;
            q_q     <= '0;
            sh      <= '0;
            cnt     <= '0;
            so_q    <= 1'b0;
            si_en_q <= 1'b0;
            soc_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_d;
            phase   <= phase_d;
            step_q  <= step_d;
            q_q     <= q_d;
            sh      <= sh_d;
            cnt     <= cnt_d;
            so_q    <= so_d;
            si_en_q <= si_en_d;
            soc_q   <= soc_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mag <= '0;
        end else if (state == FETCH) begin
            mag <= QROM[int'(idx)*MW +: MW];
        end
    end

    assign bus.SO      = so_q;
    assign bus.SI_en   = si_en_q;
    assign bus.soc     = soc_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = ovr_q;
endmodule
